// File: rtl/core_run_ctrl.sv
// rtl/core_run_ctrl.sv - run/step/halt sequencer producing the core commit strobe
// Optional retire-count halt enabled by defining RETIRE_LIMIT_EN.
module core_run_ctrl #(
    parameter int          DIV        = 8,
    parameter int          CNT_W      = 32,
    parameter logic [31:0] MAX_RETIRE = 32'd100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    input  logic             stop,
    input  logic [31:0]      pc,
    input  logic [31:0]      instr,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    output logic             core_en,
    output logic [1:0]       state,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] retired
);

    localparam int            DW       = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [31:0]   SELF_LOOP = 32'h0000_0063;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_STEP = 2'b10,
        S_HALT = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        HC_NONE   = 2'b00,
        HC_BP     = 2'b01,
        HC_LOOP   = 2'b10,
        HC_RETIRE = 2'b11
    } cause_t;

    state_t          cur;
    cause_t          cause;
    logic [DW-1:0]   div_cnt;
    logic            bp_skip;

    logic            active;
    logic            tick;
    logic            bp_hit;
    logic            loop_hit;
    logic            hit;
    logic            cmd;
    logic            commit;
    logic            limit_hit;
    logic            ret_full;
    logic [CNT_W-1:0] ret_next;

    assign state      = cur;
    assign halt_cause = cause;

    assign active   = (cur == S_RUN) || (cur == S_STEP);
    assign tick     = active && (div_cnt == DIV_LAST);
    assign bp_hit   = bp_en && (pc == bp_addr) && !bp_skip;
    assign loop_hit = (instr == SELF_LOOP);
    assign hit      = bp_hit || loop_hit;
    assign ret_full = (retired == {CNT_W{1'b1}});
    assign ret_next = ret_full ? retired : retired + 1'b1;

    // Only commands that actually move the FSM out of its state pre-empt a tick.
    always_comb begin
        cmd = 1'b0;
        case (cur)
            S_IDLE: cmd = start || step;
            S_RUN:  cmd = stop;
            S_STEP: cmd = stop || start;
            S_HALT: cmd = start || step || stop;
            default: cmd = 1'b0;
        endcase
    end

    assign commit  = tick && !hit && !cmd;
    assign core_en = commit;

`ifdef RETIRE_LIMIT_EN
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_RETIRE);
    assign limit_hit = !ret_full && (ret_next == LIMIT);
`else
    logic unused_max_retire;
    assign unused_max_retire = ^MAX_RETIRE;
    assign limit_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cur     <= S_IDLE;
            cause   <= HC_NONE;
            div_cnt <= '0;
            bp_skip <= 1'b0;
            retired <= '0;
        end else if (cmd) begin
            div_cnt <= '0;
            case (cur)
                S_IDLE: cur <= start ? S_RUN : S_STEP;
                S_RUN:  cur <= S_IDLE;
                S_STEP: cur <= stop ? S_IDLE : S_RUN;
                S_HALT: begin
                    cause <= HC_NONE;
                    if (stop) begin
                        cur <= S_IDLE;
                    end else begin
                        // Let the instruction that tripped the breakpoint execute once.
                        cur     <= start ? S_RUN : S_STEP;
                        bp_skip <= 1'b1;
                    end
                end
                default: cur <= S_IDLE;
            endcase
        end else if (tick) begin
            div_cnt <= '0;
            if (hit) begin
                cur   <= S_HALT;
                cause <= bp_hit ? HC_BP : HC_LOOP;
            end else begin
                retired <= ret_next;
                bp_skip <= 1'b0;
                if (limit_hit) begin
                    cur   <= S_HALT;
                    cause <= HC_RETIRE;
                end else if (cur == S_STEP) begin
                    cur <= S_IDLE;
                end
            end
        end else if (active) begin
            div_cnt <= div_cnt + DW'(1);
        end else begin
            div_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_core_run_ctrl.sv
// tb/tb_core_run_ctrl.sv - directed self-checking bench for core_run_ctrl (DIV=4)
module tb_core_run_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, step, stop, bp_en;
    logic [31:0] pc, instr, bp_addr;
    logic        core_en;
    logic [1:0]  state, halt_cause;
    logic [31:0] retired;

    int n_tests = 0;
    int n_fail  = 0;

    core_run_ctrl #(.DIV(4), .CNT_W(32), .MAX_RETIRE(32'd5)) dut (
        .clk(clk), .rst(rst), .start(start), .step(step), .stop(stop),
        .pc(pc), .instr(instr), .bp_en(bp_en), .bp_addr(bp_addr),
        .core_en(core_en), .state(state), .halt_cause(halt_cause), .retired(retired)
    );

    always #5 clk = ~clk;

    // Minimal core: PC advances by 4 on every commit.
    always @(posedge clk) begin
        if (rst) pc <= 32'h0;
        else if (core_en) pc <= pc + 32'd4;
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; start = 1'b0; step = 1'b0; stop = 1'b0;
        bp_en = 1'b0; bp_addr = 32'h0; instr = 32'h0000_0013;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_tests++;
            if (state !== 2'b00 || core_en !== 1'b0 || retired !== 32'd0 || halt_cause !== 2'b00) begin
                n_fail++;
                $display("FAIL reset c=%0d got st=%b en=%b ret=%0d hc=%b exp st=00 en=0 ret=0 hc=00",
                         c, state, core_en, retired, halt_cause);
            end
            next_cycle();
        end
    endtask

    task automatic test_run;
        logic exp_en;
        do_reset();
        for (int c = 0; c <= 13; c++) begin
            start = (c == 0);
            @(negedge clk);
            exp_en = (c == 4 || c == 8 || c == 12);
            n_tests++;
            if (core_en !== exp_en) begin
                n_fail++;
                $display("FAIL run_core_en c=%0d got %b exp %b", c, core_en, exp_en);
            end
            if (c == 13) begin
                n_tests++;
                if (retired !== 32'd3 || state !== 2'b01) begin
                    n_fail++;
                    $display("FAIL run_state got ret=%0d st=%b exp ret=3 st=01", retired, state);
                end
            end
            next_cycle();
        end
        start = 1'b0;
    endtask

    task automatic test_step;
        logic exp_en;
        do_reset();
        for (int c = 0; c <= 25; c++) begin
            step = (c == 0);
            @(negedge clk);
            exp_en = (c == 4);
            n_tests++;
            if (core_en !== exp_en) begin
                n_fail++;
                $display("FAIL step_core_en c=%0d got %b exp %b", c, core_en, exp_en);
            end
            if (c == 2 || c == 5) begin
                n_tests++;
                if (state !== ((c == 2) ? 2'b10 : 2'b00)) begin
                    n_fail++;
                    $display("FAIL step_state c=%0d got %b exp %b", c, state, (c == 2) ? 2'b10 : 2'b00);
                end
            end
            next_cycle();
        end
        step = 1'b0;
        n_tests++;
        if (retired !== 32'd1) begin
            n_fail++;
            $display("FAIL step_retired got %0d exp 1", retired);
        end
    endtask

    task automatic test_breakpoint;
        logic exp_en;
        do_reset();
        bp_en = 1'b1; bp_addr = 32'h10;
        for (int c = 0; c <= 26; c++) begin
            start = (c == 0 || c == 22);
            @(negedge clk);
            exp_en = (c == 4 || c == 8 || c == 12 || c == 16 || c == 26);
            n_tests++;
            if (core_en !== exp_en) begin
                n_fail++;
                $display("FAIL bp_core_en c=%0d got %b exp %b", c, core_en, exp_en);
            end
            if (c == 21) begin
                n_tests++;
                if (state !== 2'b11 || halt_cause !== 2'b01 || retired !== 32'd4 || pc !== 32'h10) begin
                    n_fail++;
                    $display("FAIL bp_halt got st=%b hc=%b ret=%0d pc=%h exp st=11 hc=01 ret=4 pc=10",
                             state, halt_cause, retired, pc);
                end
            end
            if (c == 23 || c == 26) begin
                n_tests++;
                if (halt_cause !== 2'b00 || state !== 2'b01 || pc !== 32'h10) begin
                    n_fail++;
                    $display("FAIL bp_resume c=%0d got hc=%b st=%b pc=%h exp hc=00 st=01 pc=10",
                             c, halt_cause, state, pc);
                end
            end
            next_cycle();
        end
        start = 1'b0; bp_en = 1'b0;
    endtask

    task automatic test_self_loop;
        logic exp_en;
        do_reset();
        for (int c = 0; c <= 15; c++) begin
            start = (c == 0);
            step  = (c == 10);
            instr = (c >= 8) ? 32'h0000_0063 : 32'h0000_0013;
            @(negedge clk);
            exp_en = (c == 4);
            n_tests++;
            if (core_en !== exp_en) begin
                n_fail++;
                $display("FAIL loop_core_en c=%0d got %b exp %b", c, core_en, exp_en);
            end
            if (c == 9 || c == 15) begin
                n_tests++;
                if (state !== 2'b11 || halt_cause !== 2'b10 || retired !== 32'd1) begin
                    n_fail++;
                    $display("FAIL loop_halt c=%0d got st=%b hc=%b ret=%0d exp st=11 hc=10 ret=1",
                             c, state, halt_cause, retired);
                end
            end
            if (c == 11) begin
                n_tests++;
                if (state !== 2'b10 || halt_cause !== 2'b00) begin
                    n_fail++;
                    $display("FAIL loop_step got st=%b hc=%b exp st=10 hc=00", state, halt_cause);
                end
            end
            next_cycle();
        end
        start = 1'b0; step = 1'b0; instr = 32'h0000_0013;
    endtask

    task automatic test_stop_and_reset;
        logic exp_en;
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            start = (c == 0 || c == 8 || c == 10);
            stop  = (c == 8);
            rst   = (c == 13);
            @(negedge clk);
            exp_en = (c == 4);
            n_tests++;
            if (core_en !== exp_en) begin
                n_fail++;
                $display("FAIL stop_core_en c=%0d got %b exp %b", c, core_en, exp_en);
            end
            if (c == 9) begin
                n_tests++;
                if (state !== 2'b00 || retired !== 32'd1) begin
                    n_fail++;
                    $display("FAIL stop_state got st=%b ret=%0d exp st=00 ret=1", state, retired);
                end
            end
            if (c == 14) begin
                n_tests++;
                if (state !== 2'b00 || retired !== 32'd0 || halt_cause !== 2'b00) begin
                    n_fail++;
                    $display("FAIL mid_reset got st=%b ret=%0d hc=%b exp st=00 ret=0 hc=00",
                             state, retired, halt_cause);
                end
            end
            next_cycle();
        end
        start = 1'b0; stop = 1'b0; rst = 1'b0;
    endtask

    task automatic test_retire_limit;
        do_reset();
        for (int c = 0; c <= 27; c++) begin
            start = (c == 0 || c == 22);
            @(negedge clk);
            if (c == 20) begin
                n_tests++;
                if (core_en !== 1'b1) begin
                    n_fail++;
                    $display("FAIL limit_commit got %b exp 1", core_en);
                end
            end
`ifdef RETIRE_LIMIT_EN
            if (c == 21) begin
                n_tests++;
                if (state !== 2'b11 || halt_cause !== 2'b11 || retired !== 32'd5) begin
                    n_fail++;
                    $display("FAIL limit_halt got st=%b hc=%b ret=%0d exp st=11 hc=11 ret=5",
                             state, halt_cause, retired);
                end
            end
            if (c == 27) begin
                n_tests++;
                if (state !== 2'b01 || halt_cause !== 2'b00 || retired !== 32'd6) begin
                    n_fail++;
                    $display("FAIL limit_resume got st=%b hc=%b ret=%0d exp st=01 hc=00 ret=6",
                             state, halt_cause, retired);
                end
            end
`else
            if (c == 21 || c == 25) begin
                n_tests++;
                if (state !== 2'b01 || halt_cause !== 2'b00 || retired !== ((c == 21) ? 32'd5 : 32'd6)) begin
                    n_fail++;
                    $display("FAIL no_limit c=%0d got st=%b hc=%b ret=%0d exp st=01 hc=00",
                             c, state, halt_cause, retired);
                end
            end
`endif
            next_cycle();
        end
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_run();
        test_step();
        test_breakpoint();
        test_self_loop();
        test_stop_and_reset();
        test_retire_limit();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
